// File: rtl/read_miss_issuer_pkg.sv
// Shared definitions for the read-miss path: default widths, issuer FSM
// states and the R_MISS_FIFO entry layout that the read-miss handler unpacks.
package read_miss_issuer_pkg;

  localparam int RMI_ADDR_WIDTH      = 32;
  localparam int RMI_TID_WIDTH       = 4;
  localparam int RMI_ID_WIDTH        = 4;
  localparam int RMI_MAX_OUTSTANDING = 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } rmi_state_t;

  // FIFO entry at default widths: tid in the MSBs, addr in the LSBs.
  typedef struct packed {
    logic [RMI_TID_WIDTH-1:0]  tid;
    logic [RMI_ADDR_WIDTH-1:0] addr;
  } rmi_fifo_entry_t;

endpackage

// File: rtl/miss_credit_counter.sv
// Outstanding-miss credit counter: +1 per issued miss, -1 per completion.
// Flags the limit so the issuer can stall, and latches a sticky error if a
// completion arrives while nothing is outstanding.
module miss_credit_counter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 at_limit,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] MaxCount = CNT_WIDTH'(MAX_OUTSTANDING);

  // Count register and sticky underflow flag; simultaneous inc/dec cancel.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: count <= count + CNT_WIDTH'(1);
        2'b01: begin
          if (count != '0) count <= count - CNT_WIDTH'(1);
          else             err   <= 1'b1;
        end
        default: count <= count;
      endcase
    end
  end

  assign at_limit = (count == MaxCount);

endmodule

// File: rtl/read_miss_issuer.sv
// Read-miss initiator: pushes {tid, addr} into R_MISS_FIFO, then issues the
// matching AR on the following cycle so the FIFO entry always precedes the
// request. In-flight misses are capped by a credit counter.
module read_miss_issuer
  import read_miss_issuer_pkg::*;
#(
  parameter int ADDR_WIDTH      = RMI_ADDR_WIDTH,
  parameter int TID_WIDTH       = RMI_TID_WIDTH,
  parameter int ID_WIDTH        = RMI_ID_WIDTH,
  parameter int MAX_OUTSTANDING = RMI_MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid_i,
  output logic                          miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
  input  logic [TID_WIDTH-1:0]          miss_tid_i,
  output logic                          write_en_o,
  input  logic                          full_i,
  output logic [ADDR_WIDTH+TID_WIDTH-1:0] wdata_fifo_o,
  output logic                          arvalid_o,
  input  logic                          arready_i,
  output logic [ADDR_WIDTH-1:0]         araddr_o,
  output logic [ID_WIDTH-1:0]           arid_o,
  input  logic                          cpl_i,
  output logic [CNT_WIDTH-1:0]          outstanding_o,
  output logic                          err_o
);

  rmi_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic                  accept;
  logic                  ar_fire;
  logic                  at_limit;

  // Next-state and handshake decode; rst masks every strobe so a reset cycle
  // never pushes the FIFO or presents an AR.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    ar_fire   = 1'b0;
    arvalid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rst && miss_valid_i && !full_i && !at_limit) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        arvalid_o = !rst;
        if (!rst && arready_i) begin
          ar_fire = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured AR address and rolling AR id.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      araddr_q <= '0;
      arid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)  araddr_q <= miss_addr_i;
      if (ar_fire) arid_q   <= arid_q + ID_WIDTH'(1);
    end
  end

  miss_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept),
    .dec      (cpl_i),
    .count    (outstanding_o),
    .at_limit (at_limit),
    .err      (err_o)
  );

  assign miss_ready_o = accept;
  assign write_en_o   = accept;
  assign wdata_fifo_o = accept ? {miss_tid_i, miss_addr_i} : '0;
  assign araddr_o     = araddr_q;
  assign arid_o       = arid_q;

endmodule

// File: tb/tb_read_miss_issuer.sv
// Self-checking bench for read_miss_issuer: FIFO pushes and AR handshakes are
// compared against queued expectations; counter, limit and reset behaviour
// are checked directly against a small model.
module tb_read_miss_issuer;

  localparam int AW  = 32;
  localparam int TW  = 4;
  localparam int IW  = 4;
  localparam int MAX = 8;
  localparam int CW  = $clog2(MAX + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } ar_exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             miss_valid_i;
  logic             miss_ready_o;
  logic [AW-1:0]    miss_addr_i;
  logic [TW-1:0]    miss_tid_i;
  logic             write_en_o;
  logic             full_i;
  logic [AW+TW-1:0] wdata_fifo_o;
  logic             arvalid_o;
  logic             arready_i;
  logic [AW-1:0]    araddr_o;
  logic [IW-1:0]    arid_o;
  logic             cpl_i;
  logic [CW-1:0]    outstanding_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

  logic [AW+TW-1:0] exp_fifo[$];
  ar_exp_t          exp_ar[$];
  logic [IW-1:0]    exp_id;
  int               exp_out;
  logic             exp_err;

  read_miss_issuer #(
    .ADDR_WIDTH      (AW),
    .TID_WIDTH       (TW),
    .ID_WIDTH        (IW),
    .MAX_OUTSTANDING (MAX),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid_i  (miss_valid_i),
    .miss_ready_o  (miss_ready_o),
    .miss_addr_i   (miss_addr_i),
    .miss_tid_i    (miss_tid_i),
    .write_en_o    (write_en_o),
    .full_i        (full_i),
    .wdata_fifo_o  (wdata_fifo_o),
    .arvalid_o     (arvalid_o),
    .arready_i     (arready_i),
    .araddr_o      (araddr_o),
    .arid_o        (arid_o),
    .cpl_i         (cpl_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop expected FIFO entries / AR beats as the DUT produces them.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_en_o) begin
        if (exp_fifo.size() == 0) check("fifo_unexpected", 1, 0);
        else                      check("wdata_fifo", wdata_fifo_o, exp_fifo.pop_front());
      end
      if (arvalid_o && arready_i) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          ar_exp_t e;
          e = exp_ar.pop_front();
          check("araddr", araddr_o, e.addr);
          check("arid", arid_o, e.id);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a miss expected to be accepted this cycle; optionally with cpl_i.
  task automatic accept_miss(input logic [AW-1:0] addr, input logic [TW-1:0] tid,
                             input logic with_cpl);
    miss_valid_i = 1'b1;
    miss_addr_i  = addr;
    miss_tid_i   = tid;
    cpl_i        = with_cpl;
    exp_fifo.push_back({tid, addr});
    exp_ar.push_back('{addr: addr, id: exp_id});
    @(negedge clk);
    check("miss_ready", miss_ready_o, 1);
    if (!with_cpl) exp_out++;
    step();
    miss_valid_i = 1'b0;
    cpl_i        = 1'b0;
  endtask

  // Hold arready low for 'delay' cycles (with a competing miss), then handshake.
  task automatic issue_ar(input logic [AW-1:0] addr, input int delay);
    arready_i = 1'b0;
    if (delay > 0) begin
      miss_valid_i = 1'b1;
      miss_addr_i  = 32'hDEAD_0000;
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("stall_arvalid", arvalid_o, 1);
      check("stall_araddr", araddr_o, addr);
      check("stall_arid", arid_o, exp_id);
      check("stall_ready", miss_ready_o, 0);
      step();
    end
    miss_valid_i = 1'b0;
    arready_i    = 1'b1;
    @(negedge clk);
    check("ar_valid", arvalid_o, 1);
    step();
    arready_i = 1'b0;
    exp_id++;
  endtask

  task automatic send_miss(input logic [AW-1:0] addr, input logic [TW-1:0] tid, input int delay);
    accept_miss(addr, tid, 1'b0);
    issue_ar(addr, delay);
  endtask

  task automatic pulse_cpl();
    cpl_i = 1'b1;
    step();
    cpl_i = 1'b0;
    if (exp_out > 0) exp_out--;
    else             exp_err = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; miss_valid_i = 1'b0; miss_addr_i = '0; miss_tid_i = '0;
    full_i = 1'b0; arready_i = 1'b0; cpl_i = 1'b0;
    exp_id = '0; exp_out = 0; exp_err = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", arvalid_o, 0);
    check("rst_ready", miss_ready_o, 0);
    check("rst_wen", write_en_o, 0);
    check("rst_err", err_o, 0);
    check("rst_out", outstanding_o, 0);
    check("rst_arid", arid_o, 0);
    step();
    rst = 1'b0;

    // 1: single miss with immediate arready
    send_miss(32'h1000, 4'd3, 0);
    @(negedge clk);
    check("t1_out", outstanding_o, 1);
    step();

    // 2: AR backpressure for 5 cycles, next request gets the next id
    send_miss(32'h2000, 4'd5, 5);
    check("t2_arid_next", arid_o, 2);

    // 3: credit limit
    for (int i = 0; i < 6; i++) send_miss(32'h3000 + 32'(i * 16), 4'(i), 0);
    @(negedge clk);
    check("t3_out_max", outstanding_o, 8);
    step();
    miss_valid_i = 1'b1; miss_addr_i = 32'h9000; miss_tid_i = 4'd9;
    @(negedge clk);
    check("t3_limit_ready", miss_ready_o, 0);
    check("t3_limit_wen", write_en_o, 0);
    step();
    cpl_i = 1'b1;
    @(negedge clk);
    check("t3_cpl_same_cycle", miss_ready_o, 0);
    step();
    exp_out--;
    accept_miss(32'h9000, 4'd9, 1'b0);
    issue_ar(32'h9000, 0);
    @(negedge clk);
    check("t3_out_after", outstanding_o, 8);
    step();

    // 4: drain, then FIFO full blocking
    for (int i = 0; i < 8; i++) pulse_cpl();
    @(negedge clk);
    check("t4_drained", outstanding_o, 0);
    check("t4_err_clear", err_o, 0);
    step();
    full_i = 1'b1; miss_valid_i = 1'b1; miss_addr_i = 32'h4000; miss_tid_i = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_full_wen", write_en_o, 0);
      check("t4_full_arvalid", arvalid_o, 0);
      step();
    end
    full_i = 1'b0;
    accept_miss(32'h4000, 4'd4, 1'b0);
    issue_ar(32'h4000, 0);

    // 5: accept + cpl at outstanding 4, then underflow
    for (int i = 0; i < 3; i++) send_miss(32'h5000 + 32'(i * 4), 4'(i + 8), 0);
    @(negedge clk);
    check("t5_out4", outstanding_o, 4);
    step();
    accept_miss(32'h5100, 4'd12, 1'b1);
    issue_ar(32'h5100, 0);
    @(negedge clk);
    check("t5_out_net", outstanding_o, 4);
    step();
    for (int i = 0; i < 4; i++) pulse_cpl();
    @(negedge clk);
    check("t5_err_pre", err_o, 0);
    step();
    pulse_cpl();
    @(negedge clk);
    check("t5_underflow_out", outstanding_o, 0);
    check("t5_err", err_o, exp_err);
    step();
    repeat (3) step();
    @(negedge clk);
    check("t5_err_sticky", err_o, 1);
    step();

    // 6: reset while AR pending
    accept_miss(32'h7000, 4'd7, 1'b0);
    @(negedge clk);
    check("t6_pending", arvalid_o, 1);
    step();
    rst = 1'b1;
    exp_ar.delete();
    @(negedge clk);
    check("t6_rst_arvalid", arvalid_o, 0);
    step();
    rst = 1'b0;
    exp_id = '0; exp_out = 0; exp_err = 1'b0;
    @(negedge clk);
    check("t6_arvalid", arvalid_o, 0);
    check("t6_out", outstanding_o, 0);
    check("t6_arid", arid_o, 0);
    check("t6_araddr", araddr_o, 0);
    check("t6_err", err_o, 0);
    step();

    // arid wrap after 16 issues
    for (int i = 0; i < 16; i++) begin
      send_miss(32'h8000 + 32'(i * 64), 4'(i), 0);
      pulse_cpl();
    end
    @(negedge clk);
    check("wrap_arid", arid_o, 0);
    step();
    send_miss(32'hA000, 4'd1, 0);

    repeat (2) step();
    check("fifo_queue_empty", exp_fifo.size(), 0);
    check("ar_queue_empty", exp_ar.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
